sram_write_decoder: RTL

- Write-path front end of the SRAM memory controller; the counterpart to the read-side encoder.
- Decodes bus requests (address, size, write data) into SRAM chip enables, byte-lane enables and word addresses.
- Holds one posted write in a latch until the SRAM port is free.
- Publishes the latched write (flag, address, data, byte enables) so the read path can merge it for read-after-write coherence.

---
 rtl/sram_write_decoder_if.sv | 39 +++
 rtl/sram_write_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_write_decoder_if.sv
// Request/response bundle between the SRAM controller bus side (master) and
// the write-path decoder (slave).
interface sram_write_decoder_if #(
  parameter int N_SRAM      = 1,
  parameter int SRAM_ADDR_W = 14
);
  logic                   req_valid;
  logic                   req_write;
  logic [31:0]            req_addr;
  logic [1:0]             req_size;
  logic [31:0]            wdata;
  logic                   req_ready;
  logic                   err;
  logic [N_SRAM-1:0]      sram_en;
  logic [3:0]             byte_en;
  logic [SRAM_ADDR_W-1:0] ram_addr;
  logic                   ram_wen;
  logic [31:0]            ram_wdata;
  logic [31:0]            read_addr;
  logic [1:0]             read_size;
  logic                   latched_flag;
  logic [31:0]            latched_addr;
  logic [31:0]            latched_data;
  logic [3:0]             latched_byte_en;

  modport master (
    output req_valid, req_write, req_addr, req_size, wdata,
    input  req_ready, err, sram_en, byte_en, ram_addr, ram_wen, ram_wdata,
           read_addr, read_size, latched_flag, latched_addr, latched_data,
           latched_byte_en
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, wdata,
    output req_ready, err, sram_en, byte_en, ram_addr, ram_wen, ram_wdata,
           read_addr, read_size, latched_flag, latched_addr, latched_data,
           latched_byte_en
  );
endinterface

// File: rtl/sram_write_decoder.sv
// SRAM write-path front end: lane/bank decode plus a one-entry posted-write latch.
// Optional macro WRITE_FORWARD_EN publishes the latch for read-path merging.
module sram_write_decoder #(
  parameter int N_SRAM       = 1,
  parameter int INVERT_CE_EN = 0,
  parameter int SRAM_ADDR_W  = 14,
  parameter int MAX_DEFER    = 4
) (
  input logic                 CLK,
  input logic                 nRST,
  sram_write_decoder_if.slave bus
);
  localparam int BANK_W = (N_SRAM > 1) ? $clog2(N_SRAM) : 1;
  localparam int CNT_W  = $clog2(MAX_DEFER + 2);
  localparam logic [N_SRAM-1:0] CE_MASK = (INVERT_CE_EN != 0) ? '1 : '0;
  localparam logic [3:0]        BE_MASK = (INVERT_CE_EN != 0) ? 4'hF : 4'h0;

  // DRAIN: latch is committing while the next write's data arrives.
  typedef enum logic [1:0] {IDLE, ADDR, HELD, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  defer_q, defer_d;
  logic [31:0]       pendAddr_q, pendAddr_d;
  logic [3:0]        pendBe_q, pendBe_d;
  logic [BANK_W-1:0] pendBank_q, pendBank_d;
  logic [31:0]       latAddr_q, latAddr_d;
  logic [31:0]       latData_q, latData_d;
  logic [3:0]        latBe_q, latBe_d;
  logic [BANK_W-1:0] latBank_q, latBank_d;
  logic              err_q, err_d;
  logic [31:0]       readAddr_q, readAddr_d;
  logic [1:0]        readSize_q, readSize_d;

  logic [3:0]        reqBe;
  logic              reqLegal;
  logic [BANK_W-1:0] reqBank;
  logic              hazard;
  logic              ready, accept, accWr, accRd, commit;
  logic              portEn, portWen;
  logic [BANK_W-1:0] portBank;
  logic [3:0]        portBe;
  logic [SRAM_ADDR_W-1:0] portAddr;
  logic [31:0]       portWdata;

  always_comb begin
    reqBe    = 4'h0;
    reqLegal = 1'b0;
    reqBank  = '0;
    case (bus.req_size)
      2'd0: begin
        reqBe    = 4'b0001 << bus.req_addr[1:0];
        reqLegal = 1'b1;
      end
      2'd1: begin
        reqBe    = 4'b0011 << bus.req_addr[1:0];
        reqLegal = !bus.req_addr[0];
      end
      2'd2: begin
        reqBe    = 4'hF;
        reqLegal = (bus.req_addr[1:0] == 2'b00);
      end
      default: begin
        reqBe    = 4'h0;
        reqLegal = 1'b0;
      end
    endcase
    if (N_SRAM > 1) reqBank = bus.req_addr[SRAM_ADDR_W+2 +: BANK_W];
  end

`ifdef WRITE_FORWARD_EN
  assign hazard = 1'b0;
`else
  // Without forwarding, a read of the pending word must wait for the commit.
  always_comb begin
    hazard = 1'b0;
    if (state_q == ADDR && bus.req_addr[31:2] == pendAddr_q[31:2]) hazard = 1'b1;
    if (state_q == HELD && bus.req_addr[31:2] == latAddr_q[31:2])   hazard = 1'b1;
  end
`endif

  always_comb begin
    state_d    = state_q;
    defer_d    = defer_q;
    pendAddr_d = pendAddr_q;
    pendBe_d   = pendBe_q;
    pendBank_d = pendBank_q;
    latAddr_d  = latAddr_q;
    latData_d  = latData_q;
    latBe_d    = latBe_q;
    latBank_d  = latBank_q;
    readAddr_d = readAddr_q;
    readSize_d = readSize_q;
    commit     = 1'b0;

    ready = !((state_q == DRAIN && !bus.req_write) ||
              (state_q == HELD && defer_q == CNT_W'(MAX_DEFER)) ||
              (!bus.req_write && reqLegal && hazard));
    accept = bus.req_valid && ready;
    accWr  = accept && reqLegal && bus.req_write;
    accRd  = accept && reqLegal && !bus.req_write;
    err_d  = accept && !reqLegal;

    if (accRd) begin
      readAddr_d = {bus.req_addr[31:2], 2'b00};
      readSize_d = bus.req_size;
    end
    if (accWr) begin
      pendAddr_d = bus.req_addr;
      pendBe_d   = reqBe;
      pendBank_d = reqBank;
    end

    case (state_q)
      IDLE: if (accWr) state_d = ADDR;
      ADDR: begin
        latAddr_d = pendAddr_q;
        latData_d = bus.wdata;
        latBe_d   = pendBe_q;
        latBank_d = pendBank_q;
        state_d   = accWr ? DRAIN : HELD;
      end
      HELD: begin
        if (defer_q == CNT_W'(MAX_DEFER)) begin
          commit  = 1'b1;
          defer_d = '0;
          state_d = IDLE;
        end else if (accRd) begin
          defer_d = defer_q + CNT_W'(1);
        end else begin
          commit  = 1'b1;
          defer_d = '0;
          state_d = accWr ? ADDR : IDLE;
        end
      end
      DRAIN: begin
        commit    = 1'b1;
        latAddr_d = pendAddr_q;
        latData_d = bus.wdata;
        latBe_d   = pendBe_q;
        latBank_d = pendBank_q;
        state_d   = accWr ? DRAIN : HELD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Single SRAM port: a commit and an accepted read never coincide.
  always_comb begin
    portEn    = 1'b0;
    portWen   = 1'b0;
    portBank  = '0;
    portBe    = 4'h0;
    portAddr  = '0;
    portWdata = 32'h0;
    if (commit) begin
      portEn    = 1'b1;
      portWen   = 1'b1;
      portBank  = latBank_q;
      portBe    = latBe_q;
      portAddr  = latAddr_q[SRAM_ADDR_W+1:2];
      portWdata = latData_q;
    end else if (accRd) begin
      portEn   = 1'b1;
      portBank = reqBank;
      portBe   = 4'hF;
      portAddr = bus.req_addr[SRAM_ADDR_W+1:2];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      defer_q    <= '0;
      pendAddr_q <= 32'h0;
      pendBe_q   <= 4'h0;
      pendBank_q <= '0;
      latAddr_q  <= 32'h0;
      latData_q  <= 32'h0;
      latBe_q    <= 4'h0;
      latBank_q  <= '0;
      err_q      <= 1'b0;
      readAddr_q <= 32'h0;
      readSize_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      defer_q    <= defer_d;
      pendAddr_q <= pendAddr_d;
      pendBe_q   <= pendBe_d;
      pendBank_q <= pendBank_d;
      latAddr_q  <= latAddr_d;
      latData_q  <= latData_d;
      latBe_q    <= latBe_d;
      latBank_q  <= latBank_d;
      err_q      <= err_d;
      readAddr_q <= readAddr_d;
      readSize_q <= readSize_d;
    end
  end

  assign bus.req_ready       = ready;
  assign bus.err             = err_q;
  assign bus.sram_en         = (portEn ? (N_SRAM'(1) << portBank) : '0) ^ CE_MASK;
  assign bus.byte_en         = portBe;
  assign bus.ram_addr        = portAddr;
  assign bus.ram_wen         = portWen;
  assign bus.ram_wdata       = portWdata;
  assign bus.read_addr       = readAddr_q;
  assign bus.read_size       = readSize_q;
  assign bus.latched_addr    = latAddr_q;
  assign bus.latched_data    = latData_q;
  assign bus.latched_byte_en = latBe_q ^ BE_MASK;
`ifdef WRITE_FORWARD_EN
  assign bus.latched_flag    = (state_q == HELD) || (state_q == DRAIN);
`else
  assign bus.latched_flag    = 1'b0;
`endif
endmodule
